// File: rtl/hem_mux_pkg.sv
// hem_mux_pkg: shared definitions for the hem POSFET mux control bus.
// The encode/decode helpers are shared with the taxel-side encoder so both
// ends agree on the active-low line mapping.
package hem_mux_pkg;

  // Mux configuration carried on the bus
  typedef enum logic [1:0] {
    CFG_LOCAL      = 2'd0,  // local POSFET only
    CFG_CONN       = 2'd1,  // connected taxel only
    CFG_CONN_LOCAL = 2'd2,  // connected + local
    CFG_OFF        = 2'd3   // off / default
  } hem_cfg_e;

  // Receive-side decoder states
  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_STABLE = 2'd1,
    ST_FAULT  = 2'd2
  } hem_state_e;

  // Active-low line pair -> configuration; every code is legal
  function automatic hem_cfg_e hem_decode(input logic [1:0] n_code);
    case (n_code)
      2'b10:   return CFG_LOCAL;
      2'b01:   return CFG_CONN;
      2'b00:   return CFG_CONN_LOCAL;
      default: return CFG_OFF;
    endcase
  endfunction

  // Configuration -> active-low line pair
  function automatic logic [1:0] hem_encode(input hem_cfg_e cfg);
    case (cfg)
      CFG_LOCAL:      return 2'b10;
      CFG_CONN:       return 2'b01;
      CFG_CONN_LOCAL: return 2'b00;
      default:        return 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/hem_mux_deglitch.sv
// hem_mux_deglitch: registers the raw active-low bus and counts how many
// consecutive cycles it has held the same value. stable_o is asserted for
// the cycle whose upcoming edge completes STABLE_CYC repeats, so a consumer
// registering on stable_o updates exactly STABLE_CYC edges after the new
// code was first sampled.
module hem_mux_deglitch
  import hem_mux_pkg::*;
#(
  parameter int STABLE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] din_i,
  output logic [1:0] sample_o,
  output logic       stable_o
);

  localparam int RW = $clog2(STABLE_CYC + 1);

  logic [1:0]    s_q;
  logic [RW-1:0] run_q, run_d;

  // Run length of the incoming value against the held sample, saturating
  always_comb begin
    run_d = run_q;
    if (din_i != s_q) begin
      run_d = '0;
    end else if (run_q != RW'(STABLE_CYC)) begin
      run_d = run_q + RW'(1);
    end
  end

  assign stable_o = (run_d == RW'(STABLE_CYC));
  assign sample_o = s_q;

  // Sample and run registers; the reset sample reads as the idle (off) code
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q   <= hem_encode(CFG_OFF);
      run_q <= '0;
    end else begin
      s_q   <= din_i;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/onehot_dec_p_hem.sv
// onehot_dec_p_hem: receive-side decoder for the hem POSFET mux control bus.
// Deglitches the active-low lines, tracks the accepted configuration, posts
// configuration changes through a one-entry valid/ready buffer and flags a
// bus that fails to settle within SETTLE_TMO cycles.
// Optional: define ONEHOT_DEC_P_HEM_FAULT_CNT_EN to add the saturating
// fault_cnt output.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_SETTLE | waiting for a stable code, timeout counter running
// ST_STABLE | code accepted, cfg_valid high while the bus matches cfg_out
// ST_FAULT  | settle timeout hit, waiting for any stable code
module onehot_dec_p_hem
  import hem_mux_pkg::*;
#(
  parameter int STABLE_CYC = 4,
  parameter int SETTLE_TMO = 16,
  parameter int FCNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       n_mux_ctrl,
  output logic [1:0]       cfg_out,
  output logic             cfg_valid,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [1:0]       evt_cfg,
  output logic             evt_ovf,
  output logic             fault,
  input  logic             fault_clr
`ifdef ONEHOT_DEC_P_HEM_FAULT_CNT_EN
  ,
  output logic [FCNT_W-1:0] fault_cnt
`endif
);

  localparam int TW = $clog2(SETTLE_TMO + 1);

  if (STABLE_CYC < 1 || SETTLE_TMO <= STABLE_CYC || FCNT_W < 1) begin : g_bad_params
    $error("onehot_dec_p_hem: need STABLE_CYC>=1, SETTLE_TMO>STABLE_CYC, FCNT_W>=1");
  end

  hem_state_e    state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  hem_cfg_e      cfg_q, cfg_d;
  hem_cfg_e      last_q, last_d;
  logic          posted_q, posted_d;
  logic          evt_valid_q, evt_valid_d;
  hem_cfg_e      evt_cfg_q, evt_cfg_d;
  logic          ovf_q, ovf_d;
  logic          fault_q, fault_d;

  logic [1:0]    sample;
  logic          stable;
  hem_cfg_e      samp_cfg;
  logic          enter_stable;
  logic          enter_fault;
  logic          new_evt;
  logic          ovf_set;

  hem_mux_deglitch #(
    .STABLE_CYC(STABLE_CYC)
  ) u_deglitch (
    .clk     (clk),
    .rst_n   (rst_n),
    .din_i   (n_mux_ctrl),
    .sample_o(sample),
    .stable_o(stable)
  );

  assign samp_cfg = hem_decode(sample);

  // Next-state logic; stabilising in the same cycle as the timeout wins
  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    enter_stable = 1'b0;
    enter_fault  = 1'b0;
    case (state_q)
      ST_SETTLE: begin
        if (stable) begin
          state_d      = ST_STABLE;
          enter_stable = 1'b1;
          tmo_d        = '0;
        end else if (tmo_q == TW'(SETTLE_TMO - 1)) begin
          state_d     = ST_FAULT;
          enter_fault = 1'b1;
          tmo_d       = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_STABLE: begin
        if (samp_cfg != cfg_q) begin
          state_d = ST_SETTLE;
          tmo_d   = '0;
        end
      end
      ST_FAULT: begin
        if (stable) begin
          state_d      = ST_STABLE;
          enter_stable = 1'b1;
        end
      end
      default: begin
        state_d = ST_SETTLE;
        tmo_d   = '0;
      end
    endcase
  end

  // Accepted configuration and change-event detection on STABLE entry.
  // A dropped event still counts as posted so the same code is not re-posted.
  always_comb begin
    cfg_d    = cfg_q;
    last_d   = last_q;
    posted_d = posted_q;
    new_evt  = 1'b0;
    if (enter_stable) begin
      cfg_d    = samp_cfg;
      last_d   = samp_cfg;
      posted_d = 1'b1;
      new_evt  = !posted_q || (samp_cfg != last_q);
    end
  end

  // One-entry event buffer with sticky overflow and fault flags
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_cfg_d   = evt_cfg_q;
    ovf_set     = 1'b0;
    if (new_evt) begin
      if (!evt_valid_q || evt_ready) begin
        evt_valid_d = 1'b1;
        evt_cfg_d   = samp_cfg;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end
    ovf_d   = ovf_set     ? 1'b1 : (fault_clr ? 1'b0 : ovf_q);
    fault_d = enter_fault ? 1'b1 : (fault_clr ? 1'b0 : fault_q);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_SETTLE;
      tmo_q       <= '0;
      cfg_q       <= CFG_OFF;
      last_q      <= CFG_OFF;
      posted_q    <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_cfg_q   <= CFG_LOCAL;
      ovf_q       <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      cfg_q       <= cfg_d;
      last_q      <= last_d;
      posted_q    <= posted_d;
      evt_valid_q <= evt_valid_d;
      evt_cfg_q   <= evt_cfg_d;
      ovf_q       <= ovf_d;
      fault_q     <= fault_d;
    end
  end

`ifdef ONEHOT_DEC_P_HEM_FAULT_CNT_EN
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  // Saturating fault counter; a new fault alongside a clear leaves it at one
  always_comb begin
    fcnt_d = fcnt_q;
    if (enter_fault) begin
      if (fault_clr) begin
        fcnt_d = FCNT_W'(1);
      end else if (!(&fcnt_q)) begin
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
    end else if (fault_clr) begin
      fcnt_d = '0;
    end
  end

  // Fault counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

  assign fault_cnt = fcnt_q;
`endif

  assign cfg_out   = cfg_q;
  assign cfg_valid = (state_q == ST_STABLE);
  assign evt_valid = evt_valid_q;
  assign evt_cfg   = evt_cfg_q;
  assign evt_ovf   = ovf_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_onehot_dec_p_hem.sv
// tb_onehot_dec_p_hem: directed bench for onehot_dec_p_hem with a
// cycle-level reference model derived from the decoder's behavioural rules.
module tb_onehot_dec_p_hem;

  localparam int SC  = 4;
  localparam int TMO = 16;
  localparam int FW  = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] n_mux_ctrl;
  logic [1:0] cfg_out;
  logic       cfg_valid;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_cfg;
  logic       evt_ovf;
  logic       fault;
  logic       fault_clr;
`ifdef ONEHOT_DEC_P_HEM_FAULT_CNT_EN
  logic [FW-1:0] fault_cnt;
`endif

  onehot_dec_p_hem #(
    .STABLE_CYC(SC),
    .SETTLE_TMO(TMO),
    .FCNT_W    (FW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .n_mux_ctrl(n_mux_ctrl),
    .cfg_out   (cfg_out),
    .cfg_valid (cfg_valid),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_cfg   (evt_cfg),
    .evt_ovf   (evt_ovf),
    .fault     (fault),
    .fault_clr (fault_clr)
`ifdef ONEHOT_DEC_P_HEM_FAULT_CNT_EN
    ,
    .fault_cnt (fault_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Active-low code -> configuration: 00->2, 01->1, 10->0, 11->3
  int         dec_tab [4] = '{2, 1, 0, 3};
  logic [1:0] m_hist[$];
  logic [1:0] m_s;
  int         m_phase;      // 0 settling, 1 stable, 2 faulted
  int         m_tmo;
  int         m_cfg, m_last, m_ev_c, m_fcnt;
  bit         m_any, m_ev_v, m_ovf, m_fault;
  bit         m_init = 0;

  task automatic model_step();
    logic [1:0] x;
    int d;
    bit stab, push, ent_st, ent_f, ovf_set;
    if (!rst_n) begin
      m_hist.delete();
      m_hist.push_back(2'b11);
      m_s = 2'b11; m_phase = 0; m_tmo = 0; m_cfg = 3; m_last = 0;
      m_any = 0; m_ev_v = 0; m_ev_c = 0; m_ovf = 0; m_fault = 0; m_fcnt = 0;
      m_init = 1;
      return;
    end
    x = n_mux_ctrl;
    d = 0;
    m_hist.push_back(x);
    if (m_hist.size() > SC + 1) void'(m_hist.pop_front());
    // Accepted once the last SC+1 samples (since reset) all agree
    stab = (m_hist.size() == SC + 1);
    foreach (m_hist[k]) if (m_hist[k] != x) stab = 0;
    ent_st = 0; ent_f = 0;
    case (m_phase)
      0: if (stab) ent_st = 1;
         else begin
           m_tmo++;
           if (m_tmo >= TMO) begin ent_f = 1; m_phase = 2; end
         end
      1: if (dec_tab[m_s] != m_cfg) begin m_phase = 0; m_tmo = 0; end
      default: if (stab) ent_st = 1;
    endcase
    push = 0;
    if (ent_st) begin
      m_phase = 1;
      d = dec_tab[x];
      m_cfg = d;
      push = !m_any || (d != m_last);
      m_any = 1;
      m_last = d;
    end
    ovf_set = 0;
    if (push) begin
      if (!m_ev_v || evt_ready) begin m_ev_v = 1; m_ev_c = d; end
      else ovf_set = 1;
    end else if (m_ev_v && evt_ready) m_ev_v = 0;
    m_ovf   = ovf_set ? 1 : (fault_clr ? 0 : m_ovf);
    m_fault = ent_f   ? 1 : (fault_clr ? 0 : m_fault);
    if (ent_f) m_fcnt = fault_clr ? 1 : ((m_fcnt < (1 << FW) - 1) ? m_fcnt + 1 : m_fcnt);
    else if (fault_clr) m_fcnt = 0;
    m_s = x;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare every cycle once the model has seen a reset edge
  initial forever begin
    @(negedge clk);
    if (m_init) begin
      chk("m_cfg_out",   int'(cfg_out),   m_cfg);
      chk("m_cfg_valid", int'(cfg_valid), int'(m_phase == 1));
      chk("m_evt_valid", int'(evt_valid), int'(m_ev_v));
      if (m_ev_v) chk("m_evt_cfg", int'(evt_cfg), m_ev_c);
      chk("m_evt_ovf",   int'(evt_ovf),   int'(m_ovf));
      chk("m_fault",     int'(fault),     int'(m_fault));
`ifdef ONEHOT_DEC_P_HEM_FAULT_CNT_EN
      chk("m_fault_cnt", int'(fault_cnt), m_fcnt);
`endif
    end
  end

  // ---------------- stimulus ----------------
  // Apply inputs for one rising edge, return at the following falling edge
  task automatic cyc(input logic [1:0] n, input logic rdy, input logic clr);
    n_mux_ctrl = n;
    evt_ready  = rdy;
    fault_clr  = clr;
    @(negedge clk);
  endtask

  task automatic cycn(input logic [1:0] n, input logic rdy, input logic clr, input int cnt);
    for (int i = 0; i < cnt; i++) cyc(n, rdy, clr);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cfg_out"},   int'(cfg_out),   3);
    chk({tag, "_cfg_valid"}, int'(cfg_valid), 0);
    chk({tag, "_evt_valid"}, int'(evt_valid), 0);
    chk({tag, "_evt_cfg"},   int'(evt_cfg),   0);
    chk({tag, "_evt_ovf"},   int'(evt_ovf),   0);
    chk({tag, "_fault"},     int'(fault),     0);
  endtask

  initial begin
    rst_n = 1'b0;
    cycn(2'b10, 1'b0, 1'b0, 2);
    chk_reset("rst");

    // Constant 10 after reset: accepted on the 5th edge (e+4)
    rst_n = 1'b1;
    cycn(2'b10, 1'b0, 1'b0, 4);
    chk("lat_early_valid", int'(cfg_valid), 0);
    cyc(2'b10, 1'b0, 1'b0);
    chk("lat_cfg_out",   int'(cfg_out),   0);
    chk("lat_cfg_valid", int'(cfg_valid), 1);
    chk("lat_evt_valid", int'(evt_valid), 1);
    chk("lat_evt_cfg",   int'(evt_cfg),   0);
    cyc(2'b10, 1'b1, 1'b0);
    chk("accept0_evt_valid", int'(evt_valid), 0);

    // Two-cycle glitch to 01
    cyc(2'b01, 1'b0, 1'b0);
    chk("glitch_first_valid", int'(cfg_valid), 1);
    cyc(2'b01, 1'b0, 1'b0);
    chk("glitch_drop_valid", int'(cfg_valid), 0);
    cycn(2'b10, 1'b0, 1'b0, 4);
    chk("glitch_still_low", int'(cfg_valid), 0);
    cyc(2'b10, 1'b0, 1'b0);
    chk("glitch_recover_valid", int'(cfg_valid), 1);
    chk("glitch_cfg_out",       int'(cfg_out),   0);
    chk("glitch_no_evt",        int'(evt_valid), 0);

    // Toggle every two cycles: settle timeout 16 edges after leaving STABLE
    for (int i = 0; i < 20; i++) begin
      cyc(((i / 2) % 2 == 1) ? 2'b10 : 2'b01, 1'b0, 1'b0);
      if (i == 16) chk("tmo_not_yet", int'(fault), 0);
      if (i == 17) chk("tmo_fault",   int'(fault), 1);
    end
`ifdef ONEHOT_DEC_P_HEM_FAULT_CNT_EN
    chk("tmo_fault_cnt", int'(fault_cnt), 1);
`endif
    cycn(2'b00, 1'b0, 1'b0, 4);
    chk("fault_hold_valid", int'(cfg_valid), 0);
    cyc(2'b00, 1'b0, 1'b0);
    chk("fault_rec_cfg",   int'(cfg_out),   2);
    chk("fault_rec_valid", int'(cfg_valid), 1);
    chk("fault_sticky",    int'(fault),     1);
    chk("fault_rec_evt",   int'(evt_cfg),   2);
    cyc(2'b00, 1'b0, 1'b1);
    chk("fault_clr", int'(fault), 0);
`ifdef ONEHOT_DEC_P_HEM_FAULT_CNT_EN
    chk("fault_cnt_clr", int'(fault_cnt), 0);
`endif

    // Overflow: hold ready low across 0 -> 3 -> 1
    cyc(2'b00, 1'b1, 1'b0);
    cycn(2'b10, 1'b0, 1'b0, 5);
    cyc(2'b10, 1'b1, 1'b0);
    chk("ovf_empty", int'(evt_valid), 0);
    cycn(2'b11, 1'b0, 1'b0, 5);
    chk("ovf_first_evt", int'(evt_cfg), 3);
    cycn(2'b01, 1'b0, 1'b0, 5);
    chk("ovf_cfg_out", int'(cfg_out),   1);
    chk("ovf_held",    int'(evt_cfg),   3);
    chk("ovf_flag",    int'(evt_ovf),   1);
    cyc(2'b01, 1'b1, 1'b1);
    chk("ovf_accept", int'(evt_valid), 0);
    chk("ovf_clr",    int'(evt_ovf),   0);

    // Handshake and new event in the same cycle
    cycn(2'b10, 1'b0, 1'b0, 5);
    cycn(2'b00, 1'b0, 1'b0, 4);
    chk("same_pending", int'(evt_cfg), 0);
    cyc(2'b00, 1'b1, 1'b0);
    chk("same_valid", int'(evt_valid), 1);
    chk("same_cfg",   int'(evt_cfg),   2);
    chk("same_noovf", int'(evt_ovf),   0);

    // Reset while settling with an event pending
    cycn(2'b11, 1'b0, 1'b0, 2);
    chk("pre_rst_valid", int'(cfg_valid), 0);
    rst_n = 1'b0;
    cyc(2'b11, 1'b0, 1'b0);
    chk_reset("midrst");
    rst_n = 1'b1;
    cycn(2'b11, 1'b0, 1'b0, 3);
    chk("post_rst_early", int'(cfg_valid), 0);
    cyc(2'b11, 1'b0, 1'b0);
    chk("post_rst_valid", int'(cfg_valid), 1);
    chk("post_rst_evt",   int'(evt_valid), 1);
    chk("post_rst_cfg",   int'(evt_cfg),   3);

    cycn(2'b11, 1'b1, 1'b0, 3);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/onehot_dec_p_hem.md
# onehot_dec_p_hem

Receive-side decoder for the hem POSFET mux control bus. It samples the active-low 2-bit `n_mux_ctrl` lines driven by the taxel's encoder and deglitches them. It recovers the 2-bit mux configuration, posts each configuration change as an event over a valid/ready handshake, and flags buses that fail to settle. It sits in the taxel readout path next to the hem and is used for configuration readback and self-test.

## Interface
- `STABLE_CYC`, 4: consecutive identical samples required before a code is accepted; must be ≥1.
- `SETTLE_TMO`, 16: maximum cycles spent unsettled before a fault is declared; must be > `STABLE_CYC`.
- `FCNT_W`, 8: width of the fault counter.
- `clk` in 1: single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `n_mux_ctrl` in 2: active-low mux control lines, synchronous to `clk`.
- `cfg_out` out 2: last accepted configuration.
- `cfg_valid` out 1: high while the bus is stable and equal to `cfg_out`.
- `evt_valid` out 1: a configuration-change event is pending.
- `evt_ready` in 1: consumer accepts the pending event.
- `evt_cfg` out 2: configuration carried by the pending event.
- `evt_ovf` out 1: sticky flag; an event was dropped.
- `fault` out 1: sticky flag; a settle timeout occurred.
- `fault_clr` in 1: clears `fault`, `evt_ovf` and `fault_cnt`.
- `fault_cnt` out `FCNT_W`: saturating count of faults; present only under the macro.

## Operation
- Decode, applied to the active-low sample: `2'b10`→0 (local POSFET), `2'b01`→1 (connected), `2'b00`→2 (connected+local), `2'b11`→3 (off/default). All four codes are legal.
- Sample register `s_q`: `s_q <= n_mux_ctrl` every cycle.
- Run counter:
  - resets to 0 when the incoming value differs from `s_q`;
  - otherwise increments, saturating at `STABLE_CYC`.
  - "Stabilise" means the run condition is met.
- State machine:
  - SETTLE, entered at reset: `cfg_valid`=0. A timeout counter increments each cycle in this state.
    - Stabilise → STABLE.
    - Timeout counter reaches `SETTLE_TMO` without stabilising → FAULT.
    - If both occur in the same cycle, stabilise wins.
  - STABLE: `cfg_valid`=1. A sample differing from `cfg_out` → SETTLE, with the timeout counter cleared.
  - FAULT: `fault`=1 (sticky), `cfg_valid`=0. Stabilise → STABLE. `fault` stays set until `fault_clr`.
- On every entry to STABLE:
  - `cfg_out` loads the decoded sample.
  - An event is posted if the decoded value differs from the last posted value, or if it is the first acceptance after reset.
- Event buffer, one entry:
  - `evt_valid` and `evt_cfg` hold until the cycle where `evt_valid && evt_ready` are both high.
  - A new event arriving while the buffer is still full (not accepted that cycle) is dropped and sets `evt_ovf`.
  - Handshake and new event in the same cycle: the new event is loaded and `evt_valid` stays 1.
- `fault_clr` in the same cycle as a new fault or overflow: the set wins.

## Timing
- Reset values: `cfg_out`=3, `cfg_valid`=0, `evt_valid`=0, `evt_cfg`=0, `evt_ovf`=0, `fault`=0, `fault_cnt`=0; state SETTLE; "last posted" = none.
- A new code first sampled at edge e and held: `cfg_out`, `cfg_valid` and `evt_valid` update at edge e+`STABLE_CYC`.
- Leaving STABLE: `cfg_valid` falls at the edge after the first differing sample.
- Fault: asserted at the edge `SETTLE_TMO` cycles after SETTLE entry if the bus has not stabilised.
- `rst_n` low mid-operation: all state returns to reset values at the next edge, and any pending event is discarded.

## Configuration
- Macro: `ONEHOT_DEC_P_HEM_FAULT_CNT_EN`.
- Defined: `fault_cnt` port exists. It increments on each SETTLE→FAULT entry, saturates at all-ones, and is cleared by `fault_clr`.
- Undefined: the port and counter are absent. The sticky `fault` flag behaves identically.

## Structure
- Shared package `hem_mux_pkg` holds:
  - the configuration enum (CFG_LOCAL=0, CFG_CONN=1, CFG_CONN_LOCAL=2, CFG_OFF=3);
  - the active-low encode/decode functions, also used by the encoder;
  - the FSM state encoding.
- Sub-module `hem_mux_deglitch` contains the sample register and run counter. It outputs `stable` and the sample.

## Test plan
- After reset, drive `n_mux_ctrl`=`2'b10` constant → at edge e+4, `cfg_out`=0, `cfg_valid`=1, `evt_valid`=1, `evt_cfg`=0.
- Glitch `2'b10`→`2'b01` for 2 cycles, then back to `2'b10` → `cfg_valid` drops for the glitch duration and no new event is posted; `cfg_out` stays 0.
- Toggle `n_mux_ctrl` every 2 cycles for 20 cycles → `fault`=1 at SETTLE entry + 16; `fault_cnt`=1; holding `2'b00` then gives `cfg_out`=2 while `fault` stays 1 until `fault_clr`.
- `evt_ready`=0; change the configuration 0→3→1 → first event (cfg 3) is held, `evt_ovf`=1; one ready pulse accepts cfg 3, then `evt_valid`=0.
- Raise `evt_ready` in the same cycle a new event arrives → new `evt_cfg` is loaded and `evt_valid` stays 1.
- Assert `rst_n`=0 mid-settle with an event pending → all outputs return to reset values on the next edge.
